// File: rtl/sram_1r1w_sync_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sram_1r1w_sync_pipe
// Brief    : Single-clock 1R1W SRAM model with per-byte write mask, 1- or
//            2-cycle read pipeline, selectable same-address collision policy
//            and a post-reset memory-clear sequencer.
// Options  : define SRAM_PARITY_EN to store and check per-byte even parity
//            (adds the flip_bit test hook); otherwise dout1_perr is zero.
// Revision : 1.0 - initial release
// ============================================================================
module sram_1r1w_sync_pipe #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 9,
    parameter int RAM_DEPTH    = 512,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csb0,
    input  logic [DATA_WIDTH/8-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]   din0,
    input  logic                    csb1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    output logic [DATA_WIDTH-1:0]   dout1,
    output logic                    dout1_valid,
    output logic [DATA_WIDTH/8-1:0] dout1_perr,
    output logic                    init_done
);
    localparam int                    C_NB        = DATA_WIDTH / 8;
    localparam int                    C_LAST_INT  = RAM_DEPTH - 1;
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = C_LAST_INT[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   C_DEPTH     = RAM_DEPTH[ADDR_WIDTH:0];

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    init_done_q, init_done_d;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    w_ready, w_clr_we, w_wr_en, w_rd_fire, w_coll;
    logic                    w_addr0_ok, w_addr1_ok;
    logic [DATA_WIDTH-1:0]   w_bitmask, w_merged, w_rd_data;
    logic [C_NB-1:0]         w_rd_perr;

    // Clear sequencer: walk every word once after reset, then park in READY.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_done_d = init_done_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == C_LAST_ADDR) begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
                clr_addr_d  = '0;
            end
        end
    end

    // Sequencer registers; any reset restarts the clear walk at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
        end
    end

    assign w_ready    = (state_q == ST_READY);
    assign w_clr_we   = (state_q == ST_CLEAR) && !rst;
    assign w_addr0_ok = ({1'b0, addr0} < C_DEPTH);
    assign w_addr1_ok = ({1'b0, addr1} < C_DEPTH);
    assign w_wr_en    = w_ready && !rst && !csb0 && w_addr0_ok;
    assign w_rd_fire  = w_ready && !rst && !csb1;
    assign w_coll     = w_wr_en && !csb1 && (addr0 == addr1);

    // Expand the byte enables to a bit mask for the read-modify-write merge.
    for (genvar gi = 0; gi < C_NB; gi++) begin : g_mask
        assign w_bitmask[8*gi +: 8] = {8{wmask0[gi]}};
    end

    // Word as it will look after this cycle's write (also the write-first read).
    assign w_merged = (mem[addr0] & ~w_bitmask) | (din0 & w_bitmask);

    // Read data selection: out-of-range reads zero, collisions per policy.
    always_comb begin
        w_rd_data = mem[addr1];
        if (!w_addr1_ok) begin
            w_rd_data = '0;
        end else if ((WRITE_FIRST != 0) && w_coll) begin
            w_rd_data = w_merged;
        end
    end

`ifdef SRAM_PARITY_EN
    logic [C_NB-1:0]               par_mem [RAM_DEPTH];
    logic [C_NB-1:0]               w_par_merged, w_rd_par;
    logic                          flip_seq;
    logic                          flip_seen_q;
    logic [ADDR_WIDTH-1:0]         flip_addr;
    logic [$clog2(DATA_WIDTH)-1:0] flip_idx;
    logic                          w_flip;

    function automatic logic [C_NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [C_NB-1:0] p;
        for (int i = 0; i < C_NB; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    // Test hook: request a single stored-data bit flip at the next clock edge,
    // leaving the stored parity untouched so the read path reports an error.
    task automatic flip_bit(input int addr, input int bit_idx);
        flip_addr = addr[ADDR_WIDTH-1:0];
        flip_idx  = bit_idx[$clog2(DATA_WIDTH)-1:0];
        flip_seq  = !flip_seq;
    endtask

    assign w_flip       = (flip_seq != flip_seen_q) && !rst;
    assign w_par_merged = (par_mem[addr0] & ~wmask0) | (byte_parity(din0) & wmask0);

    // Track hook requests so each call flips exactly once.
    always_ff @(posedge clk) begin
        flip_seen_q <= flip_seq;
    end

    // Parity store follows the data store; masked-off bytes keep their parity.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            par_mem[clr_addr_q] <= '0;
        end else if (w_wr_en) begin
            par_mem[addr0] <= w_par_merged;
        end
    end

    // Stored parity that belongs with the selected read data.
    always_comb begin
        w_rd_par = par_mem[addr1];
        if (!w_addr1_ok) begin
            w_rd_par = '0;
        end else if ((WRITE_FIRST != 0) && w_coll) begin
            w_rd_par = w_par_merged;
        end
    end

    assign w_rd_perr = byte_parity(w_rd_data) ^ w_rd_par;
`else
    assign w_rd_perr = '0;
`endif

    // Data store: clear walk has priority, then masked write (plus test flip).
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (w_wr_en) begin
            mem[addr0] <= w_merged;
        end
`ifdef SRAM_PARITY_EN
        if (w_flip) begin
            mem[flip_addr][flip_idx] <= !mem[flip_addr][flip_idx];
        end
`endif
    end

    // First pipeline stage captures the read result on the request edge.
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [C_NB-1:0]       s1_perr_q, s1_perr_d;

    // Stage-1 next values: data only moves when a read is accepted.
    always_comb begin
        s1_valid_d = w_rd_fire;
        s1_data_d  = s1_data_q;
        s1_perr_d  = s1_perr_q;
        if (w_rd_fire) begin
            s1_data_d = w_rd_data;
            s1_perr_d = w_rd_perr;
        end
    end

    // Stage-1 registers; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_perr_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_perr_q  <= s1_perr_d;
        end
    end

    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [C_NB-1:0]       w_out_perr;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic [C_NB-1:0]       s2_perr_q;

        // Extra stage for the two-cycle read latency.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_perr_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s1_data_q;
                s2_perr_q  <= s1_perr_q;
            end
        end

        assign w_out_valid = s2_valid_q;
        assign w_out_data  = s2_data_q;
        assign w_out_perr  = s2_perr_q;
    end else begin : g_lat1
        assign w_out_valid = s1_valid_q;
        assign w_out_data  = s1_data_q;
        assign w_out_perr  = s1_perr_q;
    end

    logic                  dout1_valid_q, dout1_valid_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic [C_NB-1:0]       dout1_perr_q, dout1_perr_d;

    // Output stage: pulse valid once per read, otherwise hold last data.
    always_comb begin
        dout1_valid_d = w_out_valid;
        dout1_d       = dout1_q;
        dout1_perr_d  = dout1_perr_q;
        if (w_out_valid) begin
            dout1_d      = w_out_data;
            dout1_perr_d = w_out_perr;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout1_valid_q <= 1'b0;
            dout1_q       <= '0;
            dout1_perr_q  <= '0;
        end else begin
            dout1_valid_q <= dout1_valid_d;
            dout1_q       <= dout1_d;
            dout1_perr_q  <= dout1_perr_d;
        end
    end

    assign dout1       = dout1_q;
    assign dout1_valid = dout1_valid_q;
    assign dout1_perr  = dout1_perr_q;
    assign init_done   = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_sync_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1r1w_sync_pipe
// Brief    : Randomised scoreboard bench for sram_1r1w_sync_pipe. Two
//            instances share one stimulus stream: latency 1 / write-first and
//            latency 2 / read-first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1r1w_sync_pipe;
    localparam int DW    = 128;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int NB    = DW / 8;

    logic          clk = 1'b0;
    logic          rst, csb0, csb1;
    logic [NB-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;

    logic [DW-1:0] dout_a, dout_b;
    logic          valid_a, valid_b, init_a, init_b;
    logic [NB-1:0] perr_a, perr_b;

    always #5 clk = ~clk;

    sram_1r1w_sync_pipe dut_a (
        .clk(clk), .rst(rst), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_a),
        .dout1_valid(valid_a), .dout1_perr(perr_a), .init_done(init_a)
    );

    sram_1r1w_sync_pipe #(.READ_LATENCY(2), .WRITE_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_b),
        .dout1_valid(valid_b), .dout1_perr(perr_b), .init_done(init_b)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] d_wf;
        logic [DW-1:0] d_rf;
        logic [NB-1:0] p_wf;
        logic [NB-1:0] p_rf;
    } exp_t;

    exp_t          sb[$];
    int            ptr[2];
    logic [DW-1:0] last[2];
    int            cyc = 0;
    int            cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] model [DEPTH];
    logic [NB-1:0] bad   [DEPTH];

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    // Drive one cycle of stimulus and update the reference model.
    task automatic step(input logic r, input logic c0, input logic [NB-1:0] m,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic c1, input logic [AW-1:0] a1);
        exp_t          e;
        logic [DW-1:0] merged;
        logic [NB-1:0] mbad;
        @(negedge clk);
        rst = r; csb0 = c0; wmask0 = m; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                model[i] = '0;
                bad[i]   = '0;
            end
        end else if (cnt >= DEPTH) begin
            merged = model[a0];
            mbad   = bad[a0];
            for (int i = 0; i < NB; i++) begin
                if (m[i]) begin
                    merged[8*i +: 8] = d0[8*i +: 8];
                    mbad[i]          = 1'b0;
                end
            end
            if (!c1) begin
                e.cyc  = cyc + 1;
                e.d_rf = model[a1];
                e.p_rf = bad[a1];
                e.d_wf = (!c0 && a0 == a1) ? merged : model[a1];
                e.p_wf = (!c0 && a0 == a1) ? mbad : bad[a1];
                sb.push_back(e);
            end
            if (!c0) begin
                model[a0] = merged;
                bad[a0]   = mbad;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b1, '0, '0, '0, 1'b1, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
        step(1'b0, 1'b0, m, a, d, 1'b1, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, a);
    endtask

    task automatic rnd(input logic r);
        step(r, 1'($urandom_range(1)), 16'($urandom), 9'($urandom_range(15)), rand_word(),
             1'($urandom_range(1)), 9'($urandom_range(15)));
    endtask

    // Check one instance's outputs after a clock edge.
    task automatic mon(input int k, input int lat, input logic v, input logic [DW-1:0] d,
                       input logic [NB-1:0] pe, input logic idn);
        exp_t          e;
        logic [DW-1:0] ed;
        logic [NB-1:0] ep;
        logic          exp_init;
        exp_init = (cnt >= DEPTH);
        n_tests++;
        if (idn !== exp_init) begin
            n_fail++;
            $display("FAIL init_done dut%0d cyc %0d: got %0b expected %0b", k, cyc, idn, exp_init);
        end
        if (rst) begin
            n_tests++;
            if (v !== 1'b0 || d !== '0 || pe !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d cyc %0d: got valid=%0b dout=%h perr=%h expected 0/0/0",
                         k, cyc, v, d, pe);
            end
            ptr[k]  = sb.size();
            last[k] = '0;
        end else if (v === 1'b1) begin
            n_tests++;
            if (ptr[k] >= sb.size()) begin
                n_fail++;
                $display("FAIL unexpected_valid dut%0d cyc %0d: got valid=1 expected 0", k, cyc);
            end else begin
                e = sb[ptr[k]];
                ptr[k]++;
                ed = (k == 0) ? e.d_wf : e.d_rf;
                ep = (k == 0) ? e.p_wf : e.p_rf;
                if (cyc != e.cyc + lat || d !== ed || pe !== ep) begin
                    n_fail++;
                    $display("FAIL read_data dut%0d: got cyc=%0d dout=%h perr=%h expected cyc=%0d dout=%h perr=%h",
                             k, cyc, d, pe, e.cyc + lat, ed, ep);
                end
                last[k] = ed;
            end
        end else begin
            n_tests++;
            if (v !== 1'b0 || d !== last[k]) begin
                n_fail++;
                $display("FAIL hold dut%0d cyc %0d: got valid=%b dout=%h expected 0 / %h", k, cyc, v, d, last[k]);
            end
            if (ptr[k] < sb.size()) begin
                n_tests++;
                if (sb[ptr[k]].cyc + lat <= cyc) begin
                    n_fail++;
                    $display("FAIL missing_valid dut%0d cyc %0d: got valid=0 expected 1", k, cyc);
                    ptr[k]++;
                end
            end
        end
    endtask

    // Monitor: count edges, then compare both instances just after each edge.
    initial begin
        ptr[0] = 0; ptr[1] = 0; last[0] = '0; last[1] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) cnt = 0;
            else     cnt++;
            #1;
            mon(0, 1, valid_a, dout_a, perr_a, init_a);
            mon(1, 2, valid_b, dout_b, perr_b, init_b);
        end
    end

    // Stimulus.
    initial begin
        rst = 1'b1; csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
        rnd(1'b1);
        rnd(1'b1);
        // CLEAR: random traffic must be ignored for exactly DEPTH cycles.
        for (int i = 0; i < DEPTH; i++) rnd(1'b0);
        for (int a = 0; a < 16; a++) rd(9'(a));
        rd(9'd255);
        rd(9'd511);
        // Byte mask.
        wr(9'd5, '1, '1);
        wr(9'd5, '0, 16'h0001);
        rd(9'd5);
        // Back-to-back reads.
        wr(9'd1, 128'h11, '1);
        wr(9'd2, 128'h22, '1);
        wr(9'd3, 128'h33, '1);
        rd(9'd1);
        rd(9'd2);
        rd(9'd3);
        idle(); idle();
        // Collision.
        wr(9'd7, {16{8'hAA}}, '1);
        step(1'b0, 1'b0, 16'h000F, 9'd7, {16{8'h55}}, 1'b0, 9'd7);
        rd(9'd7);
        idle(); idle(); idle();
        // Random traffic on a small window to force collisions.
        for (int i = 0; i < 600; i++) rnd(1'b0);
        idle(); idle(); idle();
        // Reset right after a read, then again in the middle of CLEAR.
        rd(9'd5);
        rnd(1'b1);
        for (int i = 0; i < 100; i++) rnd(1'b0);
        rnd(1'b1);
        for (int i = 0; i < DEPTH; i++) rnd(1'b0);
        for (int a = 0; a < 16; a++) rd(9'(a));
        idle(); idle(); idle();
`ifdef SRAM_PARITY_EN
        wr(9'd3, 128'h01, 16'h0001);
        idle();
        dut_a.flip_bit(3, 0);
        dut_b.flip_bit(3, 0);
        model[3][0] = ~model[3][0];
        bad[3][0]   = ~bad[3][0];
        idle();
        rd(9'd3);
        idle(); idle(); idle();
`endif
        for (int i = 0; i < 200; i++) rnd(1'b0);
        idle(); idle(); idle(); idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
